// File: rtl/vga_plot_arbiter.sv
// Shares one VGA adapter plot port between the board renderer (A) and the cursor renderer (B).
// Burst-locked round-robin arbitration, off-screen clipping, registered plot output.
//
// state | meaning
// IDLE  | no owner; one-cycle arbitration bubble, no grants
// OWN_A | A owns the port; gnt_a follows req_a
// OWN_B | B owns the port; gnt_b follows req_b
module vga_plot_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 8,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_a,
    input  logic [7:0]  x_a,
    input  logic [6:0]  y_a,
    input  logic [2:0]  colour_a,
    input  logic        last_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [7:0]  x_b,
    input  logic [6:0]  y_b,
    input  logic [2:0]  colour_b,
    input  logic        last_b,
    output logic        gnt_b,
    output logic        plot,
    output logic [7:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic [1:0]  owner,
    output logic [15:0] clip_count
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    localparam logic [7:0] IDLE_MAX  = 8'(TIMEOUT);
    localparam logic [8:0] X_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT   = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic       favour_b, favour_b_nxt;
    logic [7:0] burst_cnt, idle_cnt, burst_inc, idle_inc;
    logic       owned, own_req, own_last, xfer, leave, clipped;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;

    assign owned      = (state != IDLE);
    assign own_req    = (state == OWN_B) ? req_b : req_a;
    assign own_last   = (state == OWN_B) ? last_b : last_a;
    assign gnt_a      = (state == OWN_A) & req_a;
    assign gnt_b      = (state == OWN_B) & req_b;
    assign xfer       = owned & own_req;
    assign burst_inc  = burst_cnt + 8'd1;
    assign idle_inc   = idle_cnt + 8'd1;
    assign owner      = state;

    // The idle counter only advances on non-transfer cycles, so both exits can never race.
    assign leave = owned & ((xfer & (own_last | (burst_inc == BURST_MAX)))
                          | (~own_req & (idle_inc == IDLE_MAX)));

    assign pix_x      = (state == OWN_B) ? x_b : x_a;
    assign pix_y      = (state == OWN_B) ? y_b : y_a;
    assign pix_colour = (state == OWN_B) ? colour_b : colour_a;
    assign clipped    = ({1'b0, pix_x} >= X_LIMIT) | ({1'b0, pix_y} >= Y_LIMIT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            favour_b <= 1'b0;
        end else begin
            state    <= state_nxt;
            favour_b <= favour_b_nxt;
        end
    end

    // On a direct handoff the pointer favours the side that just left.
    always_comb begin
        state_nxt    = state;
        favour_b_nxt = favour_b;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || !favour_b)) begin
                    state_nxt = OWN_A;
                    if (req_b) favour_b_nxt = 1'b1;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                    if (req_a) favour_b_nxt = 1'b0;
                end
            end
            OWN_A: begin
                if (leave) begin
                    if (req_b) begin
                        state_nxt    = OWN_B;
                        favour_b_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            OWN_B: begin
                if (leave) begin
                    if (req_a) begin
                        state_nxt    = OWN_A;
                        favour_b_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            burst_cnt <= 8'd0;
            idle_cnt  <= 8'd0;
        end else if (!owned || leave) begin
            burst_cnt <= 8'd0;
            idle_cnt  <= 8'd0;
        end else if (xfer) begin
            burst_cnt <= burst_inc;
            idle_cnt  <= 8'd0;
        end else begin
            idle_cnt  <= idle_inc;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            plot       <= 1'b0;
            out_x      <= 8'd0;
            out_y      <= 7'd0;
            out_colour <= 3'd0;
            clip_count <= 16'd0;
        end else begin
            plot <= xfer & ~clipped;
            if (xfer && !clipped) begin
                out_x      <= pix_x;
                out_y      <= pix_y;
                out_colour <= pix_colour;
            end
            if (xfer && clipped && (clip_count != 16'hFFFF))
                clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: per-scenario grant/owner checks plus a
// scoreboard that predicts every plot/out_*/clip_count value one cycle after a transfer.
module tb_vga_plot_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;
    logic [7:0]  x_a = '0, x_b = '0;
    logic [6:0]  y_a = '0, y_b = '0;
    logic [2:0]  colour_a = '0, colour_b = '0;
    logic        gnt_a, gnt_b, plot;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [1:0]  owner;
    logic [15:0] clip_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       p;
        logic       inc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e_pop, e_new;
    logic [7:0] last_x = '0;
    logic [6:0] last_y = '0;
    logic [2:0] last_c = '0;
    int         exp_clip = 0;

    vga_plot_arbiter #(.MAX_BURST(16), .TIMEOUT(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock(clock), .resetn(resetn),
        .req_a(req_a), .x_a(x_a), .y_a(y_a), .colour_a(colour_a), .last_a(last_a), .gnt_a(gnt_a),
        .req_b(req_b), .x_b(x_b), .y_b(y_b), .colour_b(colour_b), .last_b(last_b), .gnt_b(gnt_b),
        .plot(plot), .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .owner(owner), .clip_count(clip_count)
    );

    always #5 clock = ~clock;

    // Scoreboard: sampled just before each rising edge; entries pushed now are due next sample.
    always @(negedge clock) begin
        #3;
        if (!resetn) begin
            sb_q.delete();
            last_x = '0; last_y = '0; last_c = '0;
            exp_clip = 0;
        end else begin
            if (sb_q.size() > 0) e_pop = sb_q.pop_front();
            else begin
                e_pop.p = 1'b0; e_pop.inc = 1'b0; e_pop.x = '0; e_pop.y = '0; e_pop.c = '0;
            end
            if (e_pop.inc && exp_clip < 65535) exp_clip++;
            if (e_pop.p) begin
                last_x = e_pop.x; last_y = e_pop.y; last_c = e_pop.c;
            end
            checks++;
            if (plot !== e_pop.p || out_x !== last_x || out_y !== last_y || out_colour !== last_c) begin
                failures++;
                $display("FAIL sb_output t=%0t got plot=%b (%0d,%0d,%0d) exp plot=%b (%0d,%0d,%0d)",
                         $time, plot, out_x, out_y, out_colour, e_pop.p, last_x, last_y, last_c);
            end
            checks++;
            if (clip_count !== 16'(exp_clip)) begin
                failures++;
                $display("FAIL sb_clip_count t=%0t got=%0d exp=%0d", $time, clip_count, exp_clip);
            end
            checks++;
            if ((gnt_a & gnt_b) !== 1'b0) begin
                failures++;
                $display("FAIL sb_double_grant t=%0t got gnt_a=%b gnt_b=%b exp not both", $time, gnt_a, gnt_b);
            end
            if ((gnt_a && req_a) || (gnt_b && req_b)) begin
                e_new.x = gnt_a ? x_a : x_b;
                e_new.y = gnt_a ? y_a : y_b;
                e_new.c = gnt_a ? colour_a : colour_b;
                e_new.inc = (e_new.x >= 8'd160) || (e_new.y >= 7'd120);
                e_new.p = ~e_new.inc;
            end else begin
                e_new.p = 1'b0; e_new.inc = 1'b0; e_new.x = '0; e_new.y = '0; e_new.c = '0;
            end
            sb_q.push_back(e_new);
        end
    end

    task automatic set_a(input logic r, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic l);
        req_a = r; x_a = x; y_a = y; colour_a = c; last_a = l;
    endtask

    task automatic set_b(input logic r, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic l);
        req_b = r; x_b = x; y_b = y; colour_b = c; last_b = l;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_a(1'b1, 8'd1, 7'd1, 3'd1, 1'b0);
        set_b(1'b1, 8'd2, 7'd2, 3'd2, 1'b0);
        @(negedge clock);
        #1;
        checks++;
        if (plot !== 1'b0 || out_x !== 8'd0 || out_y !== 7'd0 || out_colour !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got plot=%b (%0d,%0d,%0d) exp 0 (0,0,0)", plot, out_x, out_y, out_colour);
        end
        checks++;
        if (owner !== 2'b00 || clip_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_owner_clip got owner=%b clip=%0d exp 00 0", owner, clip_count);
        end
        checks++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_grants got %b%b exp 00", gnt_a, gnt_b);
        end
        set_a(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        set_b(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_single_a();
        int p;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            p = (i == 0) ? 0 : i - 1;
            set_a(i < 4, 8'(10 + p), 7'd20, 3'd3, i == 3);
            #1;
            checks++;
            if (gnt_a !== (i >= 1 && i <= 3) || gnt_b !== 1'b0) begin
                failures++;
                $display("FAIL single_gnt cyc=%0d got a=%b b=%b exp a=%b b=0", i, gnt_a, gnt_b, (i >= 1 && i <= 3));
            end
            checks++;
            if (owner !== ((i >= 1 && i <= 3) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL single_owner cyc=%0d got=%b", i, owner);
            end
        end
        set_a(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic test_contention();
        bit         ra[9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
        int         ai[9] = '{0, 0, 1, 0, 0, 2, 2, 0, 0};
        bit         al[9] = '{0, 0, 1, 0, 0, 1, 1, 0, 0};
        bit         rb[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        int         bi[9] = '{0, 0, 0, 0, 1, 2, 2, 2, 0};
        bit         bl[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        bit         ga[9] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
        bit         gb[9] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
        logic [1:0] ow[9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            set_a(ra[c], 8'(30 + ai[c]), 7'd40, 3'd1, al[c]);
            set_b(rb[c], 8'(50 + bi[c]), 7'd60, 3'd6, bl[c]);
            #1;
            checks++;
            if (gnt_a !== ga[c] || gnt_b !== gb[c]) begin
                failures++;
                $display("FAIL contention_gnt cyc=%0d got a=%b b=%b exp a=%b b=%b", c, gnt_a, gnt_b, ga[c], gb[c]);
            end
            checks++;
            if (owner !== ow[c]) begin
                failures++;
                $display("FAIL contention_owner cyc=%0d got=%b exp=%b", c, owner, ow[c]);
            end
        end
    endtask

    task automatic test_max_burst();
        int ka = 0, kb = 0, run = 0;
        bit prev_ga = 1'b0;
        for (int cyc = 0; cyc < 300 && ka < 40; cyc++) begin
            @(negedge clock);
            set_a(1'b1, 8'(ka), 7'd1, 3'd2, 1'b0);
            set_b(1'b1, 8'(100 + kb), 7'd2, 3'd5, 1'b1);
            #1;
            if (gnt_b) begin
                checks++;
                if (run != 16) begin
                    failures++;
                    $display("FAIL burst_len b_burst=%0d got a_run=%0d exp 16", kb, run);
                end
                checks++;
                if (!prev_ga) begin
                    failures++;
                    $display("FAIL burst_handoff b_burst=%0d got bubble before gnt_b exp none", kb);
                end
                run = 0;
                kb++;
            end
            if (gnt_a) begin
                run++;
                ka++;
            end
            prev_ga = gnt_a;
        end
        checks++;
        if (ka != 40 || kb != 2 || run != 8) begin
            failures++;
            $display("FAIL burst_totals got a=%0d b=%0d tail=%0d exp 40 2 8", ka, kb, run);
        end
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            set_a(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
            set_b(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
            #1;
            if (j == 7 || j == 8) begin
                checks++;
                if (owner !== ((j == 7) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL burst_tail_timeout idle=%0d got owner=%b", j + 1, owner);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic       ra, rb, al, bl, ega, egb;
        logic [7:0] xa, xb;
        logic [1:0] eo;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            ra  = (c <= 1) || (c == 7) || (c >= 16 && c <= 18);
            xa  = (c <= 1) ? 8'd40 : (c == 7) ? 8'd41 : 8'd42;
            al  = (c >= 16);
            rb  = (c >= 2 && c <= 17);
            xb  = (c == 17) ? 8'd91 : 8'd90;
            bl  = (c == 17);
            ega = (c == 1) || (c == 7) || (c == 18);
            egb = (c == 16) || (c == 17);
            eo  = (c == 0 || c == 19) ? 2'b00 : (c == 16 || c == 17) ? 2'b10 : 2'b01;
            set_a(ra, xa, 7'd50, 3'd1, al);
            set_b(rb, xb, 7'd10, 3'd6, bl);
            #1;
            checks++;
            if (gnt_a !== ega || gnt_b !== egb) begin
                failures++;
                $display("FAIL timeout_gnt cyc=%0d got a=%b b=%b exp a=%b b=%b", c, gnt_a, gnt_b, ega, egb);
            end
            checks++;
            if (owner !== eo) begin
                failures++;
                $display("FAIL timeout_owner cyc=%0d got=%b exp=%b", c, owner, eo);
            end
        end
        set_a(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        set_b(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic test_clip();
        logic [7:0] xb;
        logic [6:0] yb;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            xb = (c <= 1) ? 8'd160 : (c == 2) ? 8'd5 : 8'd159;
            yb = (c <= 1) ? 7'd5 : (c == 2) ? 7'd120 : 7'd119;
            set_b(c <= 3, xb, yb, 3'd4, c == 3);
            #1;
            checks++;
            if (gnt_b !== (c >= 1 && c <= 3) || gnt_a !== 1'b0) begin
                failures++;
                $display("FAIL clip_gnt cyc=%0d got b=%b a=%b", c, gnt_b, gnt_a);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (plot !== 1'b0) begin
                    failures++;
                    $display("FAIL clip_plot cyc=%0d got=%b exp=0", c, plot);
                end
            end
            if (c >= 3) begin
                checks++;
                if (clip_count !== 16'd2) begin
                    failures++;
                    $display("FAIL clip_count cyc=%0d got=%0d exp=2", c, clip_count);
                end
            end
            if (c == 4) begin
                checks++;
                if (plot !== 1'b1 || out_x !== 8'd159 || out_y !== 7'd119 || out_colour !== 3'd4) begin
                    failures++;
                    $display("FAIL clip_edge_pixel got plot=%b (%0d,%0d,%0d) exp 1 (159,119,4)",
                             plot, out_x, out_y, out_colour);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            set_a(1'b1, 8'(20 + ((c == 2) ? 1 : 0)), 7'd30, 3'd5, 1'b0);
            #1;
            checks++;
            if (gnt_a !== (c >= 1)) begin
                failures++;
                $display("FAIL midrst_pre_gnt cyc=%0d got=%b exp=%b", c, gnt_a, (c >= 1));
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (plot !== 1'b1 || owner !== 2'b01) begin
            failures++;
            $display("FAIL midrst_before got plot=%b owner=%b exp 1 01", plot, owner);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || owner !== 2'b00 || clip_count !== 16'd0 || gnt_a !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got plot=%b owner=%b clip=%0d gnt_a=%b exp 0 00 0 0",
                     plot, owner, clip_count, gnt_a);
        end
        set_a(1'b1, 8'd22, 7'd30, 3'd5, 1'b1);
        set_b(1'b1, 8'd70, 7'd80, 3'd7, 1'b1);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || owner !== 2'b00) begin
            failures++;
            $display("FAIL midrst_bubble got a=%b b=%b owner=%b exp 0 0 00", gnt_a, gnt_b, owner);
        end
        @(negedge clock);
        #1;
        checks++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || owner !== 2'b01) begin
            failures++;
            $display("FAIL midrst_favour_a got a=%b b=%b owner=%b exp 1 0 01", gnt_a, gnt_b, owner);
        end
        @(negedge clock);
        set_a(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if (gnt_b !== 1'b1 || owner !== 2'b10) begin
            failures++;
            $display("FAIL midrst_handoff got b=%b owner=%b exp 1 10", gnt_b, owner);
        end
        @(negedge clock);
        set_b(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if (owner !== 2'b00 || gnt_b !== 1'b0) begin
            failures++;
            $display("FAIL midrst_end got owner=%b b=%b exp 00 0", owner, gnt_b);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_max_burst();
        test_timeout();
        test_clip();
        test_reset_mid_burst();
        repeat (3) @(negedge clock);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter plot interface (x, y, colour, plot) between two pixel producers.
- Requester A is the board renderer; requester B is the mouse-cursor/overlay renderer.
- Performs burst-locked round-robin arbitration and drops off-screen pixels.
- Registers the winning pixel onto the adapter port.

Parameters:
- MAX_BURST, 16: max pixels one owner may issue before forced re-arbitration (1..255).
- TIMEOUT, 8: idle cycles an owner may drop req mid-burst before losing the bus (1..255).
- SCREEN_W, 160: pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120: pixels with y >= SCREEN_H are clipped.

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- req_a  in  1  A has a valid pixel on x_a/y_a/colour_a/last_a.
- x_a  in  8  A pixel x.
- y_a  in  7  A pixel y.
- colour_a  in  3  A pixel colour.
- last_a  in  1  A pixel ends A's burst.
- gnt_a  out  1  combinational; transfer from A occurs on a cycle with req_a & gnt_a.
- req_b, x_b, y_b, colour_b, last_b, gnt_b: same as A, for requester B.
- plot  out  1  registered write strobe to the adapter.
- out_x  out  8  registered pixel x.
- out_y  out  7  registered pixel y.
- out_colour  out  3  registered pixel colour.
- owner  out  2  00 none, 01 A, 10 B (registered state).
- clip_count  out  16  saturating count of clipped pixels.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE, round-robin pointer favours A.
  - Burst and timeout counters 0.
  - plot=0, out_x=0, out_y=0, out_colour=0, owner=00, clip_count=0.
  - gnt_a=gnt_b=0.
  - Reset mid-burst discards the in-flight pixel; no plot is emitted after resetn rises until a new grant.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - gnt_a=gnt_b=0; this is a one-cycle arbitration bubble.
  - Only A requesting -> OWN_A. Only B requesting -> OWN_B.
  - Both requesting -> the side favoured by the pointer; the pointer then flips to favour the other side.
  - Neither requesting -> stay in IDLE.
- OWN_X:
  - gnt_X = req_X; the other grant is 0.
  - Each transfer increments the burst counter and clears the timeout counter.
  - A cycle with req_X=0 increments the timeout counter.
- Leaving OWN_X: triggered by a transfer with last_X=1, a transfer that makes burst count = MAX_BURST, or timeout count reaching TIMEOUT.
  - If the other side is requesting that cycle, hand off directly to OWN_other (no bubble) and set the pointer to favour X.
  - Otherwise go to IDLE.
  - The burst and timeout counters clear on every exit.
- Output register: a transfer at cycle n produces plot=1 with that x/y/colour at cycle n+1 (latency 1).
  - Without a transfer, plot=0 next cycle; out_x/out_y/out_colour hold their last values.
- Clipping:
  - A transferred pixel with x >= SCREEN_W or y >= SCREEN_H is still granted and still counts toward the burst.
  - It produces plot=0, leaves the out_* registers unchanged, and increments clip_count.
  - clip_count saturates at 16'hFFFF.
- Simultaneous events:
  - last and MAX_BURST reached on the same transfer cause one exit.
  - The timeout counter cannot advance on a transfer cycle.
  - A request arriving in the same cycle the owner exits is eligible for direct handoff.
- Producers must hold x/y/colour/last stable while req=1 and gnt=0. The arbiter never grants both sides in the same cycle.

Test Plan:
- Only A requesting, 3 pixels (10,20,c=3), (11,20,c=3), (12,20,c=3), last_a on the third:
  - IDLE one cycle, then gnt_a on 3 consecutive cycles.
  - plot=1 on the 3 following cycles with matching coordinates.
  - owner 01, then 00.
- A and B request together from reset:
  - A granted first.
  - After A's last, B is granted with no bubble cycle.
  - Next contention goes to A.
- A streams 40 pixels with last_a=0, B requesting throughout (MAX_BURST=16):
  - Ownership alternates every 16 A transfers.
  - Exactly 16 gnt_a pulses precede each B burst.
- A drops req after 2 pixels for 8 cycles (TIMEOUT=8) while B requests:
  - Ownership passes to B on the 8th idle cycle.
  - A's later pixels wait for re-arbitration.
- Pixels (160,5) and (5,120) from B:
  - Both granted, plot stays 0, clip_count=2, out_* unchanged.
  - Next pixel (159,119) plots normally.
- resetn pulsed low mid-burst of A:
  - plot, owner, clip_count and gnt_a drop to 0 immediately (asynchronously).
  - After release, the arbiter re-enters IDLE and favours A.
